// File: rtl/if_fetch_buffer.sv
// IF-stage fetch buffer: holds up to DEPTH fetched (pc, inst) pairs between the
// inst-SRAM response and the IF/ID handshake, dropping responses of flushed paths.
module if_fetch_buffer #(
    parameter int PC_W      = 32,
    parameter int INST_W    = 32,
    parameter int DEPTH     = 2,
    parameter int MAX_OUTST = 2,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OUT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_fire,
    input  logic              i_resp_valid,
    input  logic [PC_W-1:0]   i_resp_pc,
    input  logic [INST_W-1:0] i_resp_inst,
    input  logic              i_flush,
    input  logic              i_id_allow_in,
    output logic              o_req_allow,
    output logic              o_if_to_id_valid,
    output logic [PC_W-1:0]   o_if_to_id_pc,
    output logic [INST_W-1:0] o_if_to_id_inst,
    output logic [CNT_W-1:0]  o_buf_count,
    output logic              o_overflow_err
);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [OUT_W-1:0]  r_outst, r_disc;
    logic              r_ovf;

    logic              w_resp, w_drop, w_pop, w_full, w_push_req, w_push;
    logic [OUT_W-1:0]  w_live;
    logic [31:0]       w_occ;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A response with nothing outstanding is stray and ignored entirely.
    assign w_resp     = i_resp_valid & (r_outst != '0);
    assign w_drop     = w_resp & (r_disc != '0);
    assign w_pop      = (r_count != '0) & i_id_allow_in & ~i_flush;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_push_req = w_resp & ~w_drop & ~i_flush;
    assign w_push     = w_push_req & (~w_full | w_pop);

    // Only requests that will actually land count against free space.
    assign w_live      = r_outst - r_disc;
    assign w_occ       = 32'(r_count) + 32'(w_live);
    assign o_req_allow = ~i_rst & ~i_flush & (r_outst < OUT_W'(MAX_OUTST)) & (w_occ < 32'(DEPTH));

    assign o_if_to_id_valid = (r_count != '0);
    assign o_if_to_id_pc    = r_pc_mem[r_rd_ptr];
    assign o_if_to_id_inst  = r_inst_mem[r_rd_ptr];
    assign o_buf_count      = r_count;
    assign o_overflow_err   = r_ovf;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= i_resp_pc;
            r_inst_mem[r_wr_ptr] <= i_resp_inst;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_outst  <= '0;
            r_disc   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case ({i_req_fire, w_resp})
                2'b10:   if (r_outst != OUT_W'(MAX_OUTST)) r_outst <= r_outst + OUT_W'(1);
                2'b01:   r_outst <= r_outst - OUT_W'(1);
                default: ;
            endcase
            if (i_flush) begin
                // Everything still in flight (minus this cycle's response) is stale.
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
                r_disc   <= r_outst - OUT_W'(w_resp);
            end else begin
                if (w_drop) r_disc <= r_disc - OUT_W'(1);
                if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
                if (w_push & ~w_pop)
                    r_count <= r_count + CNT_W'(1);
                else if (w_pop & ~w_push)
                    r_count <= r_count - CNT_W'(1);
                if (w_push_req & w_full & ~w_pop) r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed vector bench for if_fetch_buffer (DEPTH=2, MAX_OUTST=2): each row is one
// cycle's inputs plus the outputs expected during that cycle, before the clock edge.
module tb_if_fetch_buffer;

    localparam logic [31:0] P = 32'h1c00_0000;

    typedef struct {
        logic        rst, rf, rv;
        logic [31:0] pc;
        logic        fl, al;
        logic        ereq, evld;
        logic [31:0] epc;
        int          ecnt;
        logic        eovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, req_fire, resp_valid, flush, id_allow_in;
    logic [31:0] resp_pc, resp_inst;
    logic        req_allow, vld, ovf;
    logic [31:0] out_pc, out_inst;
    logic [1:0]  buf_count;

    int   total = 0;
    int   passed = 0;
    vec_t vecs[$];

    if_fetch_buffer #(.PC_W(32), .INST_W(32), .DEPTH(2), .MAX_OUTST(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_fire(req_fire), .i_resp_valid(resp_valid),
        .i_resp_pc(resp_pc), .i_resp_inst(resp_inst), .i_flush(flush),
        .i_id_allow_in(id_allow_in), .o_req_allow(req_allow), .o_if_to_id_valid(vld),
        .o_if_to_id_pc(out_pc), .o_if_to_id_inst(out_inst), .o_buf_count(buf_count),
        .o_overflow_err(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic add(input logic r, f, v, input logic [31:0] pc, input logic fl, al,
                       input logic ereq, evld, input logic [31:0] epc, input int ecnt,
                       input logic eovf);
        vec_t x;
        x.rst = r; x.rf = f; x.rv = v; x.pc = pc; x.fl = fl; x.al = al;
        x.ereq = ereq; x.evld = evld; x.epc = epc; x.ecnt = ecnt; x.eovf = eovf;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        else
            passed++;
    endtask

    // Drive one cycle's inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input logic r, f, v, input logic [31:0] pc, input logic fl, al);
        @(negedge clk);
        rst = r; req_fire = f; resp_valid = v; resp_pc = pc; resp_inst = inst_of(pc);
        flush = fl; id_allow_in = al;
        #1;
    endtask

    initial begin
        rst = 1'b1; req_fire = 1'b0; resp_valid = 1'b0; resp_pc = '0; resp_inst = '0;
        flush = 1'b0; id_allow_in = 1'b0;
        repeat (2) @(posedge clk);

        //  rst rf rv pc       fl al   req vld epc      cnt ovf
        // basic flow
        add(1, 0, 0, 0,        0, 0,   0, 0, 0,        0, 0);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 0, 0, 0,        0, 1,   0, 0, 0,        0, 0);
        add(0, 0, 1, P+'h0,    0, 1,   0, 0, 0,        0, 0);
        add(0, 0, 1, P+'h4,    0, 1,   0, 1, P+'h0,    1, 0);
        add(0, 0, 0, 0,        0, 1,   1, 1, P+'h4,    1, 0);
        add(0, 0, 0, 0,        0, 1,   1, 0, 0,        0, 0);
        // stall / fill / drain
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 0, 1, P+'h8,    0, 0,   0, 0, 0,        0, 0);
        add(0, 0, 1, P+'hc,    0, 0,   0, 1, P+'h8,    1, 0);
        add(0, 0, 0, 0,        0, 0,   0, 1, P+'h8,    2, 0);
        add(0, 0, 0, 0,        0, 1,   0, 1, P+'h8,    2, 0);
        add(0, 0, 0, 0,        0, 1,   1, 1, P+'hc,    1, 0);
        add(0, 0, 0, 0,        0, 1,   1, 0, 0,        0, 0);
        // push+pop at full across pointer wrap
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 0, 1, P+'h10,   0, 0,   0, 0, 0,        0, 0);
        add(0, 0, 1, P+'h14,   0, 0,   0, 1, P+'h10,   1, 0);
        add(0, 1, 0, 0,        0, 0,   0, 1, P+'h10,   2, 0);
        add(0, 0, 1, P+'h18,   0, 1,   0, 1, P+'h10,   2, 0);
        add(0, 0, 0, 0,        0, 1,   0, 1, P+'h14,   2, 0);
        add(0, 0, 0, 0,        0, 1,   1, 1, P+'h18,   1, 0);
        add(0, 0, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        // push at full without pop -> sticky overflow
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 0);
        add(0, 0, 1, P+'h20,   0, 0,   0, 0, 0,        0, 0);
        add(0, 0, 1, P+'h24,   0, 0,   0, 1, P+'h20,   1, 0);
        add(0, 1, 0, 0,        0, 0,   0, 1, P+'h20,   2, 0);
        add(0, 0, 1, P+'h28,   0, 0,   0, 1, P+'h20,   2, 0);
        add(0, 0, 0, 0,        0, 0,   0, 1, P+'h20,   2, 1);
        add(0, 0, 0, 0,        0, 1,   0, 1, P+'h20,   2, 1);
        add(0, 0, 0, 0,        0, 1,   1, 1, P+'h24,   1, 1);
        add(0, 0, 0, 0,        0, 0,   1, 0, 0,        0, 1);
        // flush with two in flight and one stored entry
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 1);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 1);
        add(0, 0, 1, P+'h30,   0, 0,   0, 0, 0,        0, 1);
        add(0, 1, 0, 0,        0, 0,   0, 1, P+'h30,   1, 1);
        add(0, 0, 0, 0,        1, 1,   0, 1, P+'h30,   1, 1);
        add(0, 0, 0, 0,        0, 1,   0, 0, 0,        0, 1);
        add(0, 0, 1, P+'h34,   0, 1,   0, 0, 0,        0, 1);
        add(0, 0, 1, P+'h38,   0, 1,   1, 0, 0,        0, 1);
        add(0, 1, 0, 0,        0, 1,   1, 0, 0,        0, 1);
        add(0, 0, 1, P+'h100,  0, 1,   1, 0, 0,        0, 1);
        add(0, 0, 0, 0,        0, 1,   1, 1, P+'h100,  1, 1);
        add(0, 0, 0, 0,        0, 1,   1, 0, 0,        0, 1);
        // flush coincident with response and new request
        add(0, 1, 0, 0,        0, 1,   1, 0, 0,        0, 1);
        add(0, 1, 1, P+'h40,   1, 1,   0, 0, 0,        0, 1);
        add(0, 0, 0, 0,        0, 1,   1, 0, 0,        0, 1);
        add(0, 0, 1, P+'h104,  0, 1,   1, 0, 0,        0, 1);
        add(0, 0, 0, 0,        0, 1,   1, 1, P+'h104,  1, 1);
        add(0, 0, 0, 0,        0, 0,   1, 0, 0,        0, 1);
        // mid-operation reset with count=2, outst=1
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 1);
        add(0, 1, 0, 0,        0, 0,   1, 0, 0,        0, 1);
        add(0, 0, 1, P+'h50,   0, 0,   0, 0, 0,        0, 1);
        add(0, 0, 1, P+'h54,   0, 0,   0, 1, P+'h50,   1, 1);
        add(0, 1, 0, 0,        0, 0,   0, 1, P+'h50,   2, 1);
        add(1, 0, 0, 0,        0, 0,   0, 0, 0,        0, 0);
        add(0, 0, 1, P+'h58,   0, 1,   1, 0, 0,        0, 0);
        add(0, 0, 0, 0,        0, 1,   1, 0, 0,        0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rf, vecs[i].rv, vecs[i].pc, vecs[i].fl, vecs[i].al);
            if (!vecs[i].rst) begin
                chk("req_allow", i, 32'(req_allow), 32'(vecs[i].ereq));
                chk("valid", i, 32'(vld), 32'(vecs[i].evld));
                chk("buf_count", i, 32'(buf_count), vecs[i].ecnt);
                chk("overflow_err", i, 32'(ovf), 32'(vecs[i].eovf));
                if (vecs[i].evld) begin
                    chk("pc", i, out_pc, vecs[i].epc);
                    chk("inst", i, out_inst, inst_of(vecs[i].epc));
                end
            end
        end

        // Head must stay put over a long ID stall with a full buffer.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, P+'h200, 0, 0);
        drive(0, 0, 1, P+'h204, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("hold_pc", 100 + k, out_pc, P+'h200);
            chk("hold_inst", 100 + k, out_inst, inst_of(P+'h200));
            chk("hold_count", 100 + k, 32'(buf_count), 2);
            chk("hold_req_allow", 100 + k, 32'(req_allow), 0);
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("drain_pc0", 104, out_pc, P+'h200);
        drive(0, 0, 0, 0, 0, 1);
        chk("drain_pc1", 105, out_pc, P+'h204);
        drive(0, 0, 0, 0, 0, 1);
        chk("drain_valid", 106, 32'(vld), 0);
        chk("drain_req_allow", 106, 32'(req_allow), 1);
        chk("drain_overflow_err", 106, 32'(ovf), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Parametrised successor to the single-bit IF ready-go holder. It buffers up to DEPTH fetched instructions (pc + inst) between the instruction SRAM response and the ID stage.
- Tracks outstanding fetch requests. Silently discards responses that belong to a flushed (cancelled) path.
- Drives the IF→ID valid, and gates new fetch requests so the buffer can never overflow.
- Sits in the IF stage between the inst-SRAM interface and the IF/ID handshake.

Parameters:
PC_W, 32, width of pc field
INST_W, 32, width of instruction field
DEPTH, 2, buffer entries (≥1, power of 2 not required)
MAX_OUTST, 2, maximum outstanding fetch requests (≥1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_fire  in  1  fetch request accepted by SRAM this cycle (addr_ok & req)
resp_valid  in  1  fetch response returned this cycle (data_ok)
resp_pc  in  PC_W  pc of returned instruction
resp_inst  in  INST_W  returned instruction
flush  in  1  redirect (branch taken / exception / ertn); cancels current path
id_allow_in  in  1  ID stage can accept this cycle
req_allow  out  1  IF may issue a new fetch request this cycle
if_to_id_valid  out  1  head entry valid toward ID
if_to_id_pc  out  PC_W  head entry pc
if_to_id_inst  out  INST_W  head entry inst
buf_count  out  clog2(DEPTH+1)  occupied entries
overflow_err  out  1  sticky: push attempted while full

Behaviour:
- Reset: all outputs and state are 0. This covers count, pointers, outstanding, discard counter and overflow_err. req_allow is 1 once rst deasserts.
- Storage is a circular FIFO with rd_ptr/wr_ptr wrapping at DEPTH-1 → 0. Entry contents are not reset.
- outst: number of issued requests not yet responded. Next value = outst + req_fire − resp_valid.
  - Saturates at 0: a response with outst=0 is ignored and does not underflow.
- disc: number of responses still to be dropped.
- Flush cycle:
  - Buffer emptied next cycle: count=0, rd_ptr=wr_ptr.
  - disc ← outst − resp_valid, using current-cycle values. The response arriving in the flush cycle is itself dropped.
  - A req_fire in the flush cycle belongs to the new path and is not discarded.
  - No pop in the flush cycle, even if id_allow_in=1.
- Non-flush response handling:
  - If resp_valid and disc≠0: response dropped, disc decrements.
  - If resp_valid and disc=0: push.
- Push latency: 1 cycle. A response pushed in cycle N is visible on if_to_id_* in N+1. There is no combinational bypass.
- if_to_id_valid = (count≠0). The if_to_id_pc/inst outputs show the entry at rd_ptr.
- Pop: if_to_id_valid & id_allow_in & ~flush; advances rd_ptr.
- Push and pop in the same cycle: count unchanged. This is legal at count=DEPTH.
- req_allow = ~flush & (outst < MAX_OUTST) & (count + (outst − disc) < DEPTH).
  - Live (not-to-be-dropped) requests plus stored entries must never exceed DEPTH.
- Push when count=DEPTH with no pop: push ignored, overflow_err set to 1. It stays 1 until rst.
- Output holding: while if_to_id_valid=1 and id_allow_in=0, if_to_id_* are held stable. This generalises the old ready-go hold.
- Reset asserted mid-operation: all in-flight state is lost. Responses after reset are pushed normally only if outst>0; otherwise they are ignored.
- buf_count range is 0..DEPTH. Widths are computed with $clog2.

Test Plan:
- Basic flow (DEPTH=2, MAX_OUTST=2): issue 2 requests, responses pc=0x1c000000 then 0x1c000004, id_allow_in=1.
  - Expect if_to_id_valid 1 for two consecutive cycles, starting 1 cycle after each response, with matching pcs. buf_count never exceeds 1.
- Stall/fill: id_allow_in=0, 2 responses arrive.
  - Expect buf_count=2, req_allow=0, head pc stable.
  - Raise id_allow_in: both drain in order over 2 cycles; req_allow returns to 1.
- Flush with in-flight: outst=2, assert flush with no response that cycle.
  - Expect buf_count=0 next cycle, disc=2.
  - Next two responses dropped; third response (new path, pc=0x1c000100) appears on if_to_id_pc.
- Flush coincident with response and req_fire: outst=1, resp_valid=1, req_fire=1, flush=1.
  - Expect the response dropped, disc=0, outst=1.
  - The next response is pushed.
- Simultaneous push/pop at full: count=2, resp_valid=1, id_allow_in=1.
  - Expect count stays 2, FIFO order preserved across pointer wrap, overflow_err=0.
  - Force a push at full with id_allow_in=0: overflow_err=1, persists until rst.
- Mid-operation reset: rst asserted with count=2 and outst=1.
  - Expect next cycle count=0, outst=0, if_to_id_valid=0, req_allow=1 after release.
